// File: rtl/qram_pkg.sv
// qram_pkg: shared state type, width helper and parity function for the QBit RAM burst controller.
package qram_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, READ} qram_state_e;
   localparam int PAR_MAX_W = 64;
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/qram_burst_ctrl_if.sv
// qram_burst_ctrl_if: per-channel request, write-data and shared read-data bundle.
interface qram_burst_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int CHANNELS = 2,
   parameter int BURST_MAX = 4
);
   import qram_pkg::*;
   localparam int LEN_W = clog2_min1(BURST_MAX);
   localparam int CH_W = clog2_min1(CHANNELS);
   logic [CHANNELS-1:0] req_valid, req_ready, req_write, wd_valid, wd_ready;
   logic [CHANNELS*ADDR_W-1:0] req_addr;
   logic [CHANNELS*LEN_W-1:0] req_len;
   logic [CHANNELS*DATA_W-1:0] wd_data;
   logic rd_valid, rd_last, rd_perr;
   logic [DATA_W-1:0] rd_data;
   logic [CH_W-1:0] rd_ch;
   modport master (
      output req_valid, req_write, req_addr, req_len, wd_valid, wd_data,
      input req_ready, wd_ready, rd_valid, rd_data, rd_ch, rd_last, rd_perr
   );
   modport slave (
      input req_valid, req_write, req_addr, req_len, wd_valid, wd_data,
      output req_ready, wd_ready, rd_valid, rd_data, rd_ch, rd_last, rd_perr
   );
endinterface

// File: rtl/qram_rr_arbiter.sv
// qram_rr_arbiter: first requester at or after the priority pointer wins; one-hot grant plus index.
module qram_rr_arbiter #(
   parameter int CHANNELS = 2,
   parameter int CH_W = qram_pkg::clog2_min1(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [CH_W-1:0]     ptr_i,
   output logic [CHANNELS-1:0] gnt_o,
   output logic [CH_W-1:0]     idx_o,
   output logic                any_o
);
   always_comb begin
      int c;
      gnt_o = '0;
      idx_o = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         c = (int'(ptr_i) + i) % CHANNELS;
         if (gnt_o == '0 && req_i[c]) begin
            gnt_o[c] = 1'b1;
            idx_o = CH_W'(c);
         end
      end
   end
   assign any_o = |req_i;
endmodule

// File: rtl/qram_burst_ctrl.sv
// qram_burst_ctrl: round-robin multi-channel read/write burst controller over the QBit RAM array.
// Define QRAM_PARITY_EN to store an even-parity bit per word and flag mismatches on rd_perr.
module qram_burst_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int CHANNELS = 2,
   parameter int BURST_MAX = 4
) (
   input logic clk,
   input logic rst_n,
   qram_burst_ctrl_if.slave bus
);
   import qram_pkg::*;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int LEN_W = clog2_min1(BURST_MAX);
   localparam int CH_W = clog2_min1(CHANNELS);
`ifdef QRAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   qram_state_e state_q, state_d;
   logic [CH_W-1:0] ptr_q, ptr_d, ch_q, ch_d, gnt_idx;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0] gnt;
   logic gnt_any, wr_beat, rd_issue, last_beat, perr;
   logic [DATA_W-1:0] wdat;
   logic [MEM_W-1:0] wr_word, rd_word;
   logic [MEM_W-1:0] mem [DEPTH];
   logic rd_valid_q, rd_last_q, rd_perr_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [CH_W-1:0] rd_ch_q;

   qram_rr_arbiter #(.CHANNELS(CHANNELS), .CH_W(CH_W)) u_arb (
      .req_i(bus.req_valid),
      .ptr_i(ptr_q),
      .gnt_o(gnt),
      .idx_o(gnt_idx),
      .any_o(gnt_any)
   );

   assign wr_beat = (state_q == WRITE) && bus.wd_valid[ch_q];
   assign rd_issue = (state_q == READ);
   assign last_beat = (cnt_q == '0);
   assign wdat = bus.wd_data[ch_q*DATA_W +: DATA_W];
   assign rd_word = mem[addr_q];
`ifdef QRAM_PARITY_EN
   assign wr_word = {even_parity(PAR_MAX_W'(wdat)), wdat};
   assign perr = rd_word[DATA_W] != even_parity(PAR_MAX_W'(rd_word[DATA_W-1:0]));
`else
   assign wr_word = wdat;
   assign perr = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q <= '0;
         ch_q <= '0;
         addr_q <= '0;
         cnt_q <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q <= 1'b0;
         rd_perr_q <= 1'b0;
         rd_data_q <= '0;
         rd_ch_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         ch_q <= ch_d;
         addr_q <= addr_d;
         cnt_q <= cnt_d;
         rd_valid_q <= rd_issue;
         rd_last_q <= rd_issue && last_beat;
         rd_perr_q <= rd_issue && perr;
         if (rd_issue) begin
            rd_data_q <= rd_word[DATA_W-1:0];
            rd_ch_q <= ch_q;
         end
      end
   end

   // Storage is deliberately left out of reset so contents survive a mid-burst abort.
   always_ff @(posedge clk) begin
      if (wr_beat) mem[addr_q] <= wr_word;
   end

   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      ch_d = ch_q;
      addr_d = addr_q;
      cnt_d = cnt_q;
      if (state_q == IDLE && gnt_any) begin
         state_d = bus.req_write[gnt_idx] ? WRITE : READ;
         ptr_d = (gnt_idx == CH_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
         ch_d = gnt_idx;
         addr_d = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
         cnt_d = bus.req_len[gnt_idx*LEN_W +: LEN_W];
      end else if (wr_beat || rd_issue) begin
         state_d = last_beat ? IDLE : state_q;
         addr_d = addr_q + 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   // The accept pulse is combinational in IDLE; gating with rst_n keeps it low while reset is held.
   always_comb begin
      bus.req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
      bus.wd_ready = (state_q == WRITE) ? (CHANNELS'(1) << ch_q) : '0;
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data = rd_data_q;
   assign bus.rd_ch = rd_ch_q;
   assign bus.rd_last = rd_last_q;
   assign bus.rd_perr = rd_perr_q;
endmodule

// File: tb/tb_qram_burst_ctrl.sv
// tb_qram_burst_ctrl: directed scenarios for qram_burst_ctrl with default parameters.
module tb_qram_burst_ctrl;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int CHANNELS = 2;
   localparam int BURST_MAX = 4;
   localparam int LEN_W = 2;

   logic clk, rst_n;
   int n_cmp, n_mis;
   logic [7:0] rd_buf [4];
   logic rd_lst [4];
   logic rd_chn [4];
   logic rd_per [4];
   int rd_cyc [4];
   int rd_n;
   logic [CHANNELS-1:0] stall_wdr;

   qram_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS), .BURST_MAX(BURST_MAX)) bus ();

   qram_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   task automatic do_request(input int c, input bit wr, input int a, input int l, output bit ok);
      bus.req_write[c] = wr;
      bus.req_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
      bus.req_len[c*LEN_W +: LEN_W] = LEN_W'(l);
      bus.req_valid[c] = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = bus.req_ready[c];
         @(posedge clk);
         #1;
      end
      bus.req_valid[c] = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_mis++;
         $display("FAIL grant_timeout ch=%0d got=0 want=1", c);
      end
   endtask

   task automatic do_write(input int c, input int a, input int l, input logic [31:0] dw, input int stall_at, input int stall_n);
      bit ok;
      do_request(c, 1'b1, a, l, ok);
      if (!ok) return;
      for (int i = 0; i <= l; i++) begin
         if (i == stall_at) begin
            bus.wd_valid[c] = 1'b0;
            bus.wd_data[c*DATA_W +: DATA_W] = 8'hEE;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               stall_wdr = bus.wd_ready;
               @(posedge clk);
               #1;
            end
         end
         bus.wd_valid[c] = 1'b1;
         bus.wd_data[c*DATA_W +: DATA_W] = dw[i*8 +: 8];
         @(posedge clk);
         #1;
      end
      bus.wd_valid[c] = 1'b0;
   endtask

   task automatic do_read(input int c, input int a, input int l);
      bit ok;
      rd_n = 0;
      for (int i = 0; i < 4; i++) begin
         rd_buf[i] = 'x;
         rd_lst[i] = 'x;
         rd_chn[i] = 'x;
         rd_per[i] = 'x;
         rd_cyc[i] = -100;
      end
      do_request(c, 1'b0, a, l, ok);
      if (!ok) return;
      for (int t = 0; t < l + 3; t++) begin
         @(negedge clk);
         if (bus.rd_valid && rd_n < 4) begin
            rd_buf[rd_n] = bus.rd_data;
            rd_lst[rd_n] = bus.rd_last;
            rd_chn[rd_n] = bus.rd_ch;
            rd_per[rd_n] = bus.rd_perr;
            rd_cyc[rd_n] = t;
            rd_n++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr = '0;
      bus.req_len = '0;
      bus.wd_valid = '0;
      bus.wd_data = '0;
      stall_wdr = '0;
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = 2'b11;
      @(negedge clk);
      n_cmp++;
      if ({bus.req_ready, bus.wd_ready} !== 4'b0000) begin
         n_mis++;
         $display("FAIL reset_ready got=%b/%b want=00/00", bus.req_ready, bus.wd_ready);
      end
      n_cmp++;
      if ({bus.rd_valid, bus.rd_last, bus.rd_perr, bus.rd_ch} !== 4'b0000) begin
         n_mis++;
         $display("FAIL reset_rd_flags got=%b%b%b%b want=0000", bus.rd_valid, bus.rd_last, bus.rd_perr, bus.rd_ch);
      end
      n_cmp++;
      if (bus.rd_data !== 8'h00) begin
         n_mis++;
         $display("FAIL reset_rd_data got=%h want=00", bus.rd_data);
      end
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_arbitration();
      logic [1:0] g [4];
      int gc [4];
      int ng;
      ng = 0;
      bus.req_write = '0;
      bus.req_addr = '0;
      bus.req_len = '0;
      bus.req_valid = 2'b11;
      for (int t = 0; t < 20 && ng < 4; t++) begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            g[ng] = bus.req_ready;
            gc[ng] = t;
            ng++;
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (ng !== 4) begin
         n_mis++;
         $display("FAIL arb_grant_count got=%0d want=4", ng);
      end
      for (int i = 0; i < 4 && i < ng; i++) begin
         n_cmp++;
         if (g[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_mis++;
            $display("FAIL arb_grant%0d got=%b want=%b", i, g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
         end
      end
      if (ng == 4) begin
         n_cmp++;
         if (gc[3] - gc[0] !== 6) begin
            n_mis++;
            $display("FAIL arb_spacing got=%0d want=6", gc[3] - gc[0]);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] e;
      do_write(0, 3, 3, 32'h44332211, -1, 0);
      do_read(0, 3, 3);
      n_cmp++;
      if (rd_n !== 4) begin
         n_mis++;
         $display("FAIL basic_beats got=%0d want=4", rd_n);
      end
      for (int i = 0; i < 4; i++) begin
         e = 8'(8'h11 * (i + 1));
         n_cmp++;
         if (rd_buf[i] !== e) begin
            n_mis++;
            $display("FAIL basic_data%0d got=%h want=%h", i, rd_buf[i], e);
         end
         n_cmp++;
         if ({rd_lst[i], rd_chn[i], rd_per[i]} !== {i == 3, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL basic_flags%0d got=%b%b%b want=%b00", i, rd_lst[i], rd_chn[i], rd_per[i], i == 3);
         end
      end
      n_cmp++;
      if (rd_cyc[3] - rd_cyc[0] !== 3) begin
         n_mis++;
         $display("FAIL basic_consecutive got=%0d want=3", rd_cyc[3] - rd_cyc[0]);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] e;
      do_write(0, 14, 3, 32'hA3A2A1A0, -1, 0);
      do_read(0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         e = 8'hA2 + 8'(i);
         n_cmp++;
         if ({rd_buf[i], rd_lst[i]} !== {e, i == 1}) begin
            n_mis++;
            $display("FAIL wrap_low%0d got=%h/%b want=%h/%b", i, rd_buf[i], rd_lst[i], e, i == 1);
         end
      end
      do_read(1, 14, 3);
      for (int i = 0; i < 4; i++) begin
         e = 8'hA0 + 8'(i);
         n_cmp++;
         if ({rd_buf[i], rd_chn[i], rd_lst[i]} !== {e, 1'b1, i == 3}) begin
            n_mis++;
            $display("FAIL wrap_ch1_%0d got=%h/%b/%b want=%h/1/%b", i, rd_buf[i], rd_chn[i], rd_lst[i], e, i == 3);
         end
      end
   endtask

   task automatic test_write_stall();
      logic [7:0] e;
      do_write(1, 12, 0, 32'h00000077, -1, 0);
      do_write(1, 8, 3, 32'h54535251, 2, 3);
      n_cmp++;
      if (stall_wdr !== 2'b10) begin
         n_mis++;
         $display("FAIL stall_wd_ready got=%b want=10", stall_wdr);
      end
      do_read(0, 8, 3);
      for (int i = 0; i < 4; i++) begin
         e = 8'h51 + 8'(i);
         n_cmp++;
         if (rd_buf[i] !== e) begin
            n_mis++;
            $display("FAIL stall_data%0d got=%h want=%h", i, rd_buf[i], e);
         end
      end
      do_read(0, 12, 0);
      n_cmp++;
      if ({rd_buf[0], rd_lst[0]} !== {8'h77, 1'b1}) begin
         n_mis++;
         $display("FAIL stall_neighbour got=%h/%b want=77/1", rd_buf[0], rd_lst[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] rr [8];
      logic [7:0] dat [8];
      logic chn [8];
      logic lst [8];
      logic [7:0] vm;
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.req_write = '0;
      bus.req_addr = {4'd14, 4'd3};
      bus.req_len = {2'd0, 2'd1};
      bus.req_valid = 2'b11;
      vm = '0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         rr[t] = bus.req_ready;
         vm[t] = bus.rd_valid;
         dat[t] = bus.rd_data;
         chn[t] = bus.rd_ch;
         lst[t] = bus.rd_last;
         @(posedge clk);
         #1;
         bus.req_valid = bus.req_valid & ~rr[t];
      end
      bus.req_valid = '0;
      n_cmp++;
      if ({rr[0], rr[3]} !== 4'b0110) begin
         n_mis++;
         $display("FAIL b2b_grants got=%b,%b want=01,10", rr[0], rr[3]);
      end
      n_cmp++;
      if (vm !== 8'b0010_1100) begin
         n_mis++;
         $display("FAIL b2b_valid_mask got=%b want=00101100", vm);
      end
      n_cmp++;
      if ({dat[2], dat[3], chn[3], lst[2], lst[3]} !== {8'h11, 8'h22, 1'b0, 1'b0, 1'b1}) begin
         n_mis++;
         $display("FAIL b2b_ch0_beats got=%h,%h/%b/%b%b want=11,22/0/01", dat[2], dat[3], chn[3], lst[2], lst[3]);
      end
      n_cmp++;
      if ({dat[5], chn[5], lst[5]} !== {8'hA0, 1'b1, 1'b1}) begin
         n_mis++;
         $display("FAIL b2b_ch1_beat got=%h/%b/%b want=a0/1/1", dat[5], chn[5], lst[5]);
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      int cnt;
      logic busy;
      logic [7:0] e;
      do_request(0, 1'b0, 3, 3, ok);
      cnt = 0;
      for (int t = 0; t < 10 && cnt < 2; t++) begin
         @(negedge clk);
         if (bus.rd_valid) cnt++;
      end
      n_cmp++;
      if (cnt !== 2) begin
         n_mis++;
         $display("FAIL rst_mid_beats_before got=%0d want=2", cnt);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.rd_valid, bus.rd_last, bus.rd_data} !== 10'h000) begin
         n_mis++;
         $display("FAIL rst_mid_async got=%b/%b/%h want=0/0/00", bus.rd_valid, bus.rd_last, bus.rd_data);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      busy = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         busy = busy | bus.rd_valid | (|bus.wd_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_mis++;
         $display("FAIL rst_mid_idle got=%b want=0", busy);
      end
      do_read(0, 3, 3);
      for (int i = 0; i < 4; i++) begin
         e = 8'(8'h11 * (i + 1));
         n_cmp++;
         if (rd_buf[i] !== e) begin
            n_mis++;
            $display("FAIL rst_mid_mem%0d got=%h want=%h", i, rd_buf[i], e);
         end
      end
   endtask

   task automatic test_parity();
`ifdef QRAM_PARITY_EN
      dut.mem[5][DATA_W] = ~dut.mem[5][DATA_W];
      do_read(0, 5, 1);
      n_cmp++;
      if ({rd_per[0], rd_per[1]} !== 2'b10) begin
         n_mis++;
         $display("FAIL parity_flag got=%b%b want=10", rd_per[0], rd_per[1]);
      end
`else
      do_read(0, 5, 1);
      n_cmp++;
      if ({rd_per[0], rd_per[1]} !== 2'b00) begin
         n_mis++;
         $display("FAIL parity_off got=%b%b want=00", rd_per[0], rd_per[1]);
      end
`endif
      n_cmp++;
      if ({rd_buf[0], rd_buf[1]} !== 16'h3344) begin
         n_mis++;
         $display("FAIL parity_data got=%h%h want=3344", rd_buf[0], rd_buf[1]);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      test_reset();
      test_arbitration();
      test_basic();
      test_wrap();
      test_write_stall();
      test_back_to_back();
      test_reset_mid_read();
      test_parity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/qram_burst_ctrl.md
# qram_burst_ctrl

Parametrised multi-channel burst controller for the on-chip QBit RAM. Up to CHANNELS requesters share one DEPTH-word storage array through a round-robin arbiter. Each granted request is a read or write burst of 1..BURST_MAX words with address wrap-around. It succeeds the single-port fixed-width QBit RAM path and sits between the QBit datapath and the storage array.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- CHANNELS, 2, number of requesters (1..8)
- BURST_MAX, 4, maximum beats per burst (power of two); LEN_W = clog2(BURST_MAX), min 1

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  CHANNELS  per-channel request pending
- req_ready  out  CHANNELS  one-hot accept pulse
- req_write  in  CHANNELS  1 = write burst, 0 = read burst
- req_addr  in  CHANNELS*ADDR_W  packed start address, channel c at [c*ADDR_W +: ADDR_W]
- req_len  in  CHANNELS*LEN_W  packed length; beats = req_len+1
- wd_valid  in  CHANNELS  write data valid
- wd_data  in  CHANNELS*DATA_W  packed write data
- wd_ready  out  CHANNELS  write data pull, only for the granted channel
- rd_valid  out  1  read data valid
- rd_data  out  DATA_W  read data
- rd_ch  out  clog2(CHANNELS) (min 1)  channel owning rd_data
- rd_last  out  1  final beat of read burst
- rd_perr  out  1  parity error on rd_data (see Configuration)

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - If any req_valid, grant the first valid channel at or after the priority pointer.
  - Pulse req_ready[g] for one cycle and latch addr, len and g.
  - Go to WRITE or READ per req_write[g].
  - Set the priority pointer to (g+1) mod CHANNELS.
- WRITE:
  - wd_ready[g]=1. Each cycle with wd_valid[g]=1 writes mem[addr]; addr increments mod DEPTH; the beat count decrements.
  - After the last beat, go to IDLE.
  - wd_valid low stalls without timeout.
- READ:
  - Issue one read per cycle with addr incrementing mod DEPTH. There is no read backpressure.
  - After the last read is issued, go to IDLE.
- Wrap: a burst at addr DEPTH-1 continues at 0.
- Non-granted channels see req_ready=0 and wd_ready=0. Their inputs are ignored.
- Requests change only while not accepted; inputs are sampled only on the grant cycle.
- Reset values: req_ready=0, wd_ready=0, rd_valid=0, rd_data=0, rd_ch=0, rd_last=0, rd_perr=0. FSM is in IDLE and the priority pointer is 0.
- Reset mid-burst aborts immediately; in-flight read data is discarded. Memory contents are not reset.

## Timing
- Grant to first beat: the cycle after the req_ready pulse.
- Read latency: rd_valid asserts 1 cycle after each read issue. A burst of N beats yields N consecutive rd_valid cycles, with rd_last on the Nth.
- A write burst of N beats with wd_valid held high occupies N cycles. The final write is visible to a read issued the next cycle.
- Minimum gap between bursts is 1 IDLE cycle, so back-to-back grants occur at most every N+1 cycles.
- If a read's last rd_valid overlaps the next grant cycle, both happen; they are independent.

## Configuration
- QRAM_PARITY_EN defined:
  - Memory stores DATA_W+1 bits; the extra bit is even parity of wd_data.
  - rd_perr = 1 with rd_valid when the stored parity mismatches.
- Without the macro: memory stores DATA_W bits and rd_perr is tied to 0.

## Structure
- Shared package qram_pkg holds:
  - FSM state typedef (IDLE/WRITE/READ)
  - the clog2 helper
  - the parity function
- One sub-module, qram_rr_arbiter: parametrised round-robin grant from a request vector and priority pointer, returning a one-hot grant plus index.
- The storage array is inferred inside qram_burst_ctrl.

## Test plan
- Defaults. Ch0 writes addr 3, len 3, data 0x11..0x44, then reads addr 3, len 3 -> rd_data 0x11,0x22,0x33,0x44 on consecutive cycles, rd_last on 0x44, rd_ch=0.
- Wrap: write addr 14, len 3, data A0..A3, then read addr 0, len 1 -> 0xA2, 0xA3.
- Arbitration: ch0 and ch1 both request continuously -> grants alternate 0,1,0,1. After reset the first grant is 0.
- Write stall: wd_valid low for 3 cycles mid-burst -> addr frozen, no spurious write, burst completes with correct data.
- Reset asserted during read beat 2 of 4 -> rd_valid=0 within the same cycle (async). After release, FSM is idle and prior memory contents are intact.
- QRAM_PARITY_EN: force a stored parity bit flip via hierarchical poke -> rd_perr=1 on that beat only. Without the macro, rd_perr stays 0.
